// File: rtl/encoder_4_2.sv
// Clocked 4-to-2 encoder with fixed-priority multi-hot resolution.
// Index, valid and multi-hot flags are captured together in one register stage.
module encoder_4_2 #(
    parameter bit PRIORITY_MSB = 1'b1,
    parameter bit HOLD_ON_ZERO = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] i,
    output logic [1:0] o,
    output logic       valid,
    output logic       multi
);

    logic [1:0] o_q;
    logic [1:0] o_d;
    logic       valid_q;
    logic       valid_d;
    logic       multi_q;
    logic       multi_d;
    logic [1:0] idx_msb_s;
    logic [1:0] idx_lsb_s;
    logic [2:0] pop_s;

    // Highest-set-bit index (bit 3 wins).
    always_comb begin
        idx_msb_s = 2'd0;
        if (i[3]) begin
            idx_msb_s = 2'd3;
        end else if (i[2]) begin
            idx_msb_s = 2'd2;
        end else if (i[1]) begin
            idx_msb_s = 2'd1;
        end else begin
            idx_msb_s = 2'd0;
        end
    end

    // Lowest-set-bit index (bit 0 wins).
    always_comb begin
        idx_lsb_s = 2'd0;
        if (i[0]) begin
            idx_lsb_s = 2'd0;
        end else if (i[1]) begin
            idx_lsb_s = 2'd1;
        end else if (i[2]) begin
            idx_lsb_s = 2'd2;
        end else if (i[3]) begin
            idx_lsb_s = 2'd3;
        end else begin
            idx_lsb_s = 2'd0;
        end
    end

    // Next-state for the output register stage.
    always_comb begin
        o_d     = 2'd0;
        valid_d = 1'b0;
        multi_d = 1'b0;
        pop_s   = {2'b00, i[0]} + {2'b00, i[1]} + {2'b00, i[2]} + {2'b00, i[3]};
        case (pop_s)
            3'd0: begin
                valid_d = 1'b0;
                multi_d = 1'b0;
                // All-zero input either parks the index at 0 or keeps the last one.
                if (HOLD_ON_ZERO) begin
                    o_d = o_q;
                end else begin
                    o_d = 2'd0;
                end
            end
            3'd1: begin
                valid_d = 1'b1;
                multi_d = 1'b0;
                o_d     = idx_msb_s;
            end
            default: begin
                valid_d = 1'b1;
                multi_d = 1'b1;
                if (PRIORITY_MSB) begin
                    o_d = idx_msb_s;
                end else begin
                    o_d = idx_lsb_s;
                end
            end
        endcase
    end

    // Output register with synchronous reset dominating the input.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_q     <= 2'd0;
            valid_q <= 1'b0;
            multi_q <= 1'b0;
        end else begin
            o_q     <= o_d;
            valid_q <= valid_d;
            multi_q <= multi_d;
        end
    end

    assign o     = o_q;
    assign valid = valid_q;
    assign multi = multi_q;

endmodule

// File: tb/tb_encoder_4_2.sv
// Scoreboard bench for encoder_4_2: four parameter combinations share one stimulus
// stream; a reference model pushes expectations, a monitor pops and compares.
module tb_encoder_4_2;

    logic       clk;
    logic       rst;
    logic [3:0] i;
    logic [1:0] o_s   [4];
    logic       v_s   [4];
    logic       m_s   [4];

    int errors;
    int checks;

    // Each entry holds 4 configs x {o[1:0], valid, multi}; config c = {PRIORITY_MSB, HOLD_ON_ZERO}.
    logic [15:0] exp_q [$];
    logic [1:0]  prev_o [4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    encoder_4_2 #(.PRIORITY_MSB(1'b0), .HOLD_ON_ZERO(1'b0)) dut0 (
        .clk(clk), .rst(rst), .i(i), .o(o_s[0]), .valid(v_s[0]), .multi(m_s[0]));
    encoder_4_2 #(.PRIORITY_MSB(1'b0), .HOLD_ON_ZERO(1'b1)) dut1 (
        .clk(clk), .rst(rst), .i(i), .o(o_s[1]), .valid(v_s[1]), .multi(m_s[1]));
    encoder_4_2 #(.PRIORITY_MSB(1'b1), .HOLD_ON_ZERO(1'b0)) dut2 (
        .clk(clk), .rst(rst), .i(i), .o(o_s[2]), .valid(v_s[2]), .multi(m_s[2]));
    encoder_4_2 #(.PRIORITY_MSB(1'b1), .HOLD_ON_ZERO(1'b1)) dut3 (
        .clk(clk), .rst(rst), .i(i), .o(o_s[3]), .valid(v_s[3]), .multi(m_s[3]));

    // Apply one input cycle and push what every configuration must show after the next edge.
    task automatic drive(input logic r, input logic [3:0] iv);
        logic [15:0] e;
        int cnt;
        int hi;
        int lo;
        int eo;
        @(posedge clk);
        #2;
        rst = r;
        i   = iv;
        e   = 16'h0000;
        cnt = $countones(iv);
        hi  = 0;
        lo  = 0;
        for (int b = 0; b < 4; b++) if (iv[b]) hi = b;
        for (int b = 3; b >= 0; b--) if (iv[b]) lo = b;
        for (int c = 0; c < 4; c++) begin
            logic pmsb;
            logic hold;
            logic ev;
            logic em;
            pmsb = (c >= 2);
            hold = (c % 2 == 1);
            if (r) begin
                eo = 0; ev = 1'b0; em = 1'b0;
            end else if (cnt == 0) begin
                eo = hold ? int'(prev_o[c]) : 0;
                ev = 1'b0; em = 1'b0;
            end else begin
                eo = pmsb ? hi : lo;
                ev = 1'b1;
                em = (cnt >= 2);
            end
            prev_o[c] = eo[1:0];
            e[c*4 +: 4] = {eo[1:0], ev, em};
        end
        exp_q.push_back(e);
    endtask

    // Monitor: outputs are presented every cycle, compared just after the edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                logic [15:0] e;
                e = exp_q.pop_front();
                for (int c = 0; c < 4; c++) begin
                    checks++;
                    if (o_s[c] !== e[c*4+2 +: 2]) begin
                        errors++;
                        $display("FAIL idx cfg%0d i=%b got %0d expected %0d", c, i, o_s[c], e[c*4+2 +: 2]);
                    end
                    checks++;
                    if (v_s[c] !== e[c*4+1]) begin
                        errors++;
                        $display("FAIL valid cfg%0d got %b expected %b", c, v_s[c], e[c*4+1]);
                    end
                    checks++;
                    if (m_s[c] !== e[c*4]) begin
                        errors++;
                        $display("FAIL multi cfg%0d got %b expected %b", c, m_s[c], e[c*4]);
                    end
                end
            end
        end
    end

    initial begin
        int guard;
        errors = 0;
        checks = 0;
        rst = 1'b1;
        i   = 4'b1000;
        for (int c = 0; c < 4; c++) prev_o[c] = 2'd0;

        // Reset held two cycles with i = 8, then release.
        drive(1'b1, 4'b1000);
        drive(1'b1, 4'b1000);
        drive(1'b0, 4'b1000);
        // One-hot sweep, each held 10 cycles.
        for (int k = 0; k < 4; k++) begin
            logic [3:0] oh;
            oh = 4'b0001 << k;
            for (int n = 0; n < 10; n++) drive(1'b0, oh);
        end
        // Back-to-back changes.
        drive(1'b0, 4'b1000);
        drive(1'b0, 4'b0001);
        drive(1'b0, 4'b0100);
        drive(1'b0, 4'b0010);
        // Multi-hot priority.
        drive(1'b0, 4'b0110);
        drive(1'b0, 4'b1111);
        // Zero input after 4.
        drive(1'b0, 4'b0100);
        drive(1'b0, 4'b0000);
        drive(1'b0, 4'b0000);
        // Mid-stream reset with 8 running, then zero after reset for the held value.
        drive(1'b0, 4'b1000);
        drive(1'b1, 4'b1000);
        drive(1'b0, 4'b1000);
        drive(1'b1, 4'b0100);
        drive(1'b0, 4'b0000);
        // Randomized traffic with sparse resets and frequent zeros.
        for (int n = 0; n < 300; n++) begin
            logic r;
            logic [3:0] iv;
            r  = ($urandom_range(0, 19) == 0);
            iv = ($urandom_range(0, 4) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
            drive(r, iv);
        end

        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
